// File: rtl/write_back_unit_pkg.sv
// Shared widths and write-source encoding for the write-back stage.
package write_back_unit_pkg;

  localparam int unsigned WB_DATA_WIDTH     = 32;
  localparam int unsigned WB_GPR_ADDR_WIDTH = 3;
  localparam int unsigned WB_LOAD_DEPTH     = 2;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_LOAD = 2'd1,
    WB_SRC_SKID = 2'd2,
    WB_SRC_EX   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_load_fifo.sv
// Destination-only FIFO of outstanding loads; exposes every slot for hazard compare.
module wb_load_fifo
  import write_back_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = WB_LOAD_DEPTH,
  parameter int unsigned ADDR_W = WB_GPR_ADDR_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            push_dest_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [ADDR_W-1:0]            head_dest_o,
  output logic [DEPTH-1:0]             entry_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] entry_dest_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][ADDR_W-1:0] dest_q, dest_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;

  // Pop clears its slot before push fills one, so push+pop at full reuses the head slot.
  always_comb begin
    dest_d   = dest_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      dest_d[wr_ptr_q]  = push_dest_i;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      dest_q   <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      dest_q   <= dest_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign head_dest_o   = dest_q[rd_ptr_q];
  assign entry_valid_o = valid_q;
  assign entry_dest_o  = dest_q;

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: arbitrates load returns and execute results onto the GPR write port.
module write_back_unit
  import write_back_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned GPR_ADDR_WIDTH = WB_GPR_ADDR_WIDTH,
  parameter int unsigned LOAD_DEPTH     = WB_LOAD_DEPTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] ex_dest,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic                      load_issue_valid,
  output logic                      load_issue_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] load_issue_dest,
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_resp_data,
  input  logic                      query_en0,
  input  logic                      query_en1,
  input  logic [GPR_ADDR_WIDTH-1:0] query_addr0,
  input  logic [GPR_ADDR_WIDTH-1:0] query_addr1,
  output logic                      stall,
  output logic                      write_enable,
  output logic [GPR_ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      protocol_error
);

  logic                                     fifo_full, fifo_empty;
  logic                                     load_pop, load_push, ex_fire;
  logic [GPR_ADDR_WIDTH-1:0]                head_dest;
  logic [LOAD_DEPTH-1:0]                    entry_valid;
  logic [LOAD_DEPTH-1:0][GPR_ADDR_WIDTH-1:0] entry_dest;
  wb_src_e                                  src;

  logic                      skid_valid_q, skid_valid_d;
  logic [GPR_ADDR_WIDTH-1:0] skid_dest_q, skid_dest_d;
  logic [DATA_WIDTH-1:0]     skid_data_q, skid_data_d;
  logic                      we_q, we_d;
  logic [GPR_ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0]     wd_q, wd_d;
  logic                      perr_q, perr_d;
  logic                      hit0, hit1;

  assign ex_ready         = !skid_valid_q;
  assign load_issue_ready = !fifo_full;
  assign ex_fire          = ex_valid && !skid_valid_q;
  assign load_pop         = mem_resp_valid && !fifo_empty;
  assign load_push        = load_issue_valid && (!fifo_full || load_pop);

  wb_load_fifo #(
    .DEPTH (LOAD_DEPTH),
    .ADDR_W(GPR_ADDR_WIDTH)
  ) u_load_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (load_push),
    .push_dest_i  (load_issue_dest),
    .pop_i        (load_pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_dest_o  (head_dest),
    .entry_valid_o(entry_valid),
    .entry_dest_o (entry_dest)
  );

  // Load data always wins; a held result drains before a fresh one.
  always_comb begin
    src = WB_SRC_NONE;
    if (load_pop)          src = WB_SRC_LOAD;
    else if (skid_valid_q) src = WB_SRC_SKID;
    else if (ex_fire)      src = WB_SRC_EX;
  end

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_dest_d  = skid_dest_q;
    skid_data_d  = skid_data_q;
    we_d         = 1'b0;
    wa_d         = wa_q;
    wd_d         = wd_q;
    perr_d       = perr_q || (mem_resp_valid && fifo_empty);
    case (src)
      WB_SRC_LOAD: begin
        we_d = 1'b1;
        wa_d = head_dest;
        wd_d = mem_resp_data;
        if (ex_fire) begin
          skid_valid_d = 1'b1;
          skid_dest_d  = ex_dest;
          skid_data_d  = ex_result;
        end
      end
      WB_SRC_SKID: begin
        we_d         = 1'b1;
        wa_d         = skid_dest_q;
        wd_d         = skid_data_q;
        skid_valid_d = 1'b0;
      end
      WB_SRC_EX: begin
        we_d = 1'b1;
        wa_d = ex_dest;
        wd_d = ex_result;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      skid_valid_q <= 1'b0;
      skid_dest_q  <= '0;
      skid_data_q  <= '0;
      we_q         <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
      perr_q       <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_dest_q  <= skid_dest_d;
      skid_data_q  <= skid_data_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      perr_q       <= perr_d;
    end
  end

  // An operand is pending while any unwritten producer targets it.
  always_comb begin
    hit0 = (skid_valid_q && (skid_dest_q == query_addr0)) || (we_q && (wa_q == query_addr0));
    hit1 = (skid_valid_q && (skid_dest_q == query_addr1)) || (we_q && (wa_q == query_addr1));
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      if (entry_valid[i] && (entry_dest[i] == query_addr0)) hit0 = 1'b1;
      if (entry_valid[i] && (entry_dest[i] == query_addr1)) hit1 = 1'b1;
    end
  end

  assign stall          = (query_en0 && hit0) || (query_en1 && hit1);
  assign write_enable   = we_q;
  assign write_address  = wa_q;
  assign write_data     = wd_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_write_back_unit.sv
// Self-checking bench for write_back_unit: transaction model plus directed literal checks.
module tb_write_back_unit;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          ex_valid, ex_ready;
  logic [AW-1:0] ex_dest;
  logic [DW-1:0] ex_result;
  logic          load_issue_valid, load_issue_ready;
  logic [AW-1:0] load_issue_dest;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          query_en0, query_en1;
  logic [AW-1:0] query_addr0, query_addr1;
  logic          stall, write_enable, protocol_error;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  always #5 clock = ~clock;

  write_back_unit dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_dest(ex_dest), .ex_result(ex_result),
    .load_issue_valid(load_issue_valid), .load_issue_ready(load_issue_ready),
    .load_issue_dest(load_issue_dest),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .query_en0(query_en0), .query_en1(query_en1),
    .query_addr0(query_addr0), .query_addr1(query_addr1),
    .stall(stall), .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .protocol_error(protocol_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: pending load dests in issue order, one held result, last write.
  logic [AW-1:0] lq[$];
  bit            held_v = 0;
  logic [AW-1:0] held_a;
  logic [DW-1:0] held_d;
  bit            m_we = 0;
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  bit            m_perr = 0;

  always @(posedge clock) begin
    if (!reset) begin
      lq.delete();
      held_v = 0; m_we = 0; m_wa = '0; m_wd = '0; m_perr = 0;
    end else begin
      bit            take_ex, was_empty, nw;
      logic [AW-1:0] na;
      logic [DW-1:0] nd;
      take_ex   = ex_valid && !held_v;
      was_empty = (lq.size() == 0);
      nw = 0; na = m_wa; nd = m_wd;
      if (mem_resp_valid && !was_empty) begin
        nw = 1; na = lq.pop_front(); nd = mem_resp_data;
        if (take_ex) begin held_v = 1; held_a = ex_dest; held_d = ex_result; end
      end else if (held_v) begin
        nw = 1; na = held_a; nd = held_d; held_v = 0;
      end else if (take_ex) begin
        nw = 1; na = ex_dest; nd = ex_result;
      end
      if (mem_resp_valid && was_empty) m_perr = 1;
      if (load_issue_valid && lq.size() < DEPTH) lq.push_back(load_issue_dest);
      m_we = nw; m_wa = na; m_wd = nd;
    end
  end

  function automatic bit m_pending(input logic [AW-1:0] a);
    bit p = 0;
    foreach (lq[k]) if (lq[k] == a) p = 1;
    if (held_v && held_a == a) p = 1;
    if (m_we && m_wa == a) p = 1;
    return p;
  endfunction

  // Compare process: inputs settle at posedge+2, sampled at the falling edge.
  always @(negedge clock) begin
    if (started) begin
      bit exp_stall;
      exp_stall = (query_en0 && m_pending(query_addr0)) || (query_en1 && m_pending(query_addr1));
      chk("m_write_enable", 32'(write_enable), 32'(m_we));
      if (m_we) begin
        chk("m_write_address", 32'(write_address), 32'(m_wa));
        chk("m_write_data", write_data, m_wd);
      end
      chk("m_protocol_error", 32'(protocol_error), 32'(m_perr));
      chk("m_ex_ready", 32'(ex_ready), 32'(!held_v));
      chk("m_load_issue_ready", 32'(load_issue_ready), 32'(lq.size() < DEPTH));
      chk("m_stall", 32'(stall), 32'(exp_stall));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    ex_valid = 0; ex_dest = '0; ex_result = '0;
    load_issue_valid = 0; load_issue_dest = '0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  initial begin
    reset = 0;
    idle();
    query_en0 = 0; query_en1 = 0; query_addr0 = '0; query_addr1 = '0;
    tick(); tick();
    started = 1;
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_wa", 32'(write_address), 32'd0);
    chk("rst_wd", write_data, 32'd0);
    chk("rst_perr", 32'(protocol_error), 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_issue_ready", 32'(load_issue_ready), 32'd1);
    reset = 1;
    tick();

    // ALU write
    ex_valid = 1; ex_dest = 3'd3; ex_result = 32'h0000_00A5;
    tick(); idle();
    chk("alu_we", 32'(write_enable), 32'd1);
    chk("alu_wa", 32'(write_address), 32'd3);
    chk("alu_wd", write_data, 32'h0000_00A5);
    chk("alu_ex_ready", 32'(ex_ready), 32'd1);
    tick();
    chk("alu_we_once", 32'(write_enable), 32'd0);

    // Load round trip
    load_issue_valid = 1; load_issue_dest = 3'd5;
    tick(); idle();
    query_en0 = 1; query_addr0 = 3'd5;
    #1 chk("ld_stall_pending", 32'(stall), 32'd1);
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
    tick(); idle();
    chk("ld_we", 32'(write_enable), 32'd1);
    chk("ld_wa", 32'(write_address), 32'd5);
    chk("ld_wd", write_data, 32'h1234_5678);
    #1 chk("ld_stall_write", 32'(stall), 32'd1);
    tick();
    #1 chk("ld_stall_clear", 32'(stall), 32'd0);
    query_en0 = 0;

    // Collision: load response and execute result in the same cycle
    load_issue_valid = 1; load_issue_dest = 3'd2;
    tick(); idle();
    mem_resp_valid = 1; mem_resp_data = 32'h11;
    ex_valid = 1; ex_dest = 3'd4; ex_result = 32'h22;
    tick(); idle();
    chk("col_wa1", 32'(write_address), 32'd2);
    chk("col_wd1", write_data, 32'h11);
    chk("col_ex_ready", 32'(ex_ready), 32'd0);
    tick();
    chk("col_we2", 32'(write_enable), 32'd1);
    chk("col_wa2", 32'(write_address), 32'd4);
    chk("col_wd2", write_data, 32'h22);
    tick();

    // FIFO full, ignored issue, push+pop at full
    load_issue_valid = 1; load_issue_dest = 3'd1;
    tick();
    load_issue_dest = 3'd6;
    tick();
    chk("full_ready0", 32'(load_issue_ready), 32'd0);
    load_issue_dest = 3'd7;
    tick();
    load_issue_dest = 3'd3; mem_resp_valid = 1; mem_resp_data = 32'hA1;
    tick(); idle();
    chk("full_pp_wa", 32'(write_address), 32'd1);
    chk("full_pp_ready", 32'(load_issue_ready), 32'd0);
    mem_resp_valid = 1; mem_resp_data = 32'hA6;
    tick();
    chk("full_wa6", 32'(write_address), 32'd6);
    chk("full_ready1", 32'(load_issue_ready), 32'd1);
    mem_resp_data = 32'hA3;
    tick(); idle();
    chk("full_wa3", 32'(write_address), 32'd3);
    chk("full_wd3", write_data, 32'hA3);
    tick();

    // Spurious response
    mem_resp_valid = 1; mem_resp_data = 32'hDEAD;
    tick(); idle();
    chk("sp_we", 32'(write_enable), 32'd0);
    chk("sp_perr", 32'(protocol_error), 32'd1);
    tick(); tick();
    chk("sp_perr_sticky", 32'(protocol_error), 32'd1);
    load_issue_valid = 1; load_issue_dest = 3'd2;
    tick(); idle();
    query_en1 = 1; query_addr1 = 3'd2;
    #1 chk("sp_stall", 32'(stall), 32'd1);
    reset = 0;
    tick();
    reset = 1;
    #1;
    chk("sp_rst_perr", 32'(protocol_error), 32'd0);
    chk("sp_rst_stall", 32'(stall), 32'd0);
    query_en1 = 0;
    tick();

    // Reset mid-operation: two loads pending and skid full
    load_issue_valid = 1; load_issue_dest = 3'd1;
    tick();
    load_issue_dest = 3'd2;
    tick();
    load_issue_dest = 3'd3; mem_resp_valid = 1; mem_resp_data = 32'h55;
    ex_valid = 1; ex_dest = 3'd5; ex_result = 32'h66;
    tick(); idle();
    chk("mid_ex_ready0", 32'(ex_ready), 32'd0);
    chk("mid_issue_ready0", 32'(load_issue_ready), 32'd0);
    reset = 0;
    tick();
    chk("mid_we", 32'(write_enable), 32'd0);
    chk("mid_ex_ready", 32'(ex_ready), 32'd1);
    chk("mid_issue_ready", 32'(load_issue_ready), 32'd1);
    query_en0 = 1; query_en1 = 1;
    for (int a = 0; a < 8; a++) begin
      query_addr0 = AW'(a); query_addr1 = AW'(7 - a);
      #1 chk("mid_stall", 32'(stall), 32'd0);
    end
    query_en0 = 0; query_en1 = 0;
    reset = 1;
    tick(); tick();
    chk("mid_no_skid_write", 32'(write_enable), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_back_unit.md
Name: write_back_unit

Overview:
- Final pipeline stage; the writer side of the GPR file, paired with the read unit.
- Merges two write sources into the single register-file write port: ALU/shift results from execute, and in-order load data returning from data memory.
- Tracks outstanding loads in a destination FIFO.
- Drives a combinational stall back to the read stage when an operand it wants to read is not yet written.

Parameters:
DATA_WIDTH, 32, width of result, load data and write data
GPR_ADDR_WIDTH, 3, GPR address width (8 registers)
LOAD_DEPTH, 2, max outstanding loads (power of two, >=2)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset
ex_valid  input  1  execute result valid
ex_ready  output  1  result accepted when ex_valid&&ex_ready
ex_dest  input  GPR_ADDR_WIDTH  result destination
ex_result  input  DATA_WIDTH  result value
load_issue_valid  input  1  load sent to memory this cycle
load_issue_ready  output  1  load FIFO has space
load_issue_dest  input  GPR_ADDR_WIDTH  load destination
mem_resp_valid  input  1  load data returned (in issue order)
mem_resp_data  input  DATA_WIDTH  load data
query_en0, query_en1  input  1 each  read stage operand valid
query_addr0, query_addr1  input  GPR_ADDR_WIDTH each  operand addresses
stall  output  1  read stage must hold
write_enable  output  1  register file write strobe
write_address  output  GPR_ADDR_WIDTH  write address
write_data  output  DATA_WIDTH  write data
protocol_error  output  1  sticky; response with empty FIFO

Behaviour:
- Reset (reset==0 at rising edge): write_enable=0, write_address=0, write_data=0, protocol_error=0, FIFO empty, skid empty.
- Reset mid-operation discards all outstanding loads and any held result.
- Write port is registered: a selected source appears on write_* the cycle after acceptance; write_enable is high for exactly one cycle per write.
- Selection priority per cycle:
  - 1. mem_resp_valid && FIFO non-empty: write FIFO head dest with mem_resp_data; pop FIFO.
  - 2. Else skid full: write skid contents; clear skid.
  - 3. Else ex_valid: write ex_dest/ex_result directly.
- Skid buffer (1 entry):
  - ex_ready = !skid_full.
  - Execute result accepted in a cycle lost to priority 1 goes into the skid.
  - Skid never overwritten.
- Load FIFO:
  - load_issue_ready = !full.
  - Push on load_issue_valid&&ready.
  - Simultaneous push and pop allowed at any occupancy, including full (pop frees the slot first, count unchanged).
  - Pointers wrap modulo LOAD_DEPTH.
  - load_issue_valid while full is ignored (no push).
- mem_resp_valid with empty FIFO: response dropped, no write, protocol_error set until reset.
- Stall (combinational): stall=1 if, for any i with query_en_i=1, query_addr_i equals any of:
  - a valid FIFO entry dest;
  - the skid dest while skid full;
  - write_address while write_enable=1.
  - Otherwise stall=0.
- No bypass of data to the read stage; a stall lasts until the register-file write has completed.
- Multiple FIFO entries may hold the same dest; the register stays pending until all are popped.

Decomposition:
- Shared package: DATA_WIDTH/GPR_ADDR_WIDTH defaults, write-source select encoding (WB_SRC_NONE, WB_SRC_LOAD, WB_SRC_SKID, WB_SRC_EX).
- Sub-module wb_load_fifo: dest-only FIFO with push/pop/full/empty and a per-entry valid/dest vector exported for the stall compare.

Test Plan:
- ALU write: ex_valid, dest=3, result=0x0000_00A5 -> next cycle write_enable=1, address=3, data=0xA5; one cycle only; ex_ready stays 1.
- Load round trip: issue dest=5; query_addr0=5 en -> stall=1. Response 0x1234_5678 -> write r5=0x12345678 next cycle; stall=1 during that write cycle, 0 the cycle after.
- Collision:
  - Response dest=2 data=0x11 and ex dest=4 result=0x22 in same cycle -> r2 written at cycle+1, r4 from skid at cycle+2.
  - ex_ready=0 during cycle+1.
- FIFO full: LOAD_DEPTH=2, issue dests 1,6 -> load_issue_ready=0; third issue ignored. Pop+push same cycle -> ready stays 0, order preserved (r1 then r6 then new).
- Spurious response with empty FIFO -> no write_enable, protocol_error=1 and stays 1 until reset; reset clears it and stall.
- Reset mid-operation: two loads pending, skid full; reset low one edge -> write_enable=0, stall=0 for any query, ex_ready=1, load_issue_ready=1.
